reaction_score_keeper: RTL



---
 rtl/reaction_pkg.sv | 25 ++
 rtl/bcd_less4.sv | 24 ++
 rtl/reaction_score_keeper.sv | 93 +++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction tester score-keeping datapath.
package reaction_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_WORD_W  = 16;
  localparam logic [BCD_WORD_W-1:0] BEST_RESET = 16'h9999;

  typedef enum logic [1:0] {
    DISP_LIVE  = 2'd0,
    DISP_LAST  = 2'd1,
    DISP_BEST  = 2'd2,
    DISP_STATS = 2'd3
  } disp_sel_e;

  // Two-digit BCD increment that holds once the (BCD-encoded) limit is reached.
  function automatic logic [7:0] bcd2_sat_inc(input logic [7:0] v, input logic [7:0] max_bcd);
    if (v >= max_bcd)
      return v;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_less4.sv
// Combinational 4-digit BCD less-than: first differing digit from the top decides.
module bcd_less4
  import reaction_pkg::*;
(
  input  logic [BCD_WORD_W-1:0] a,
  input  logic [BCD_WORD_W-1:0] b,
  output logic                  lt
);

  logic found;

  always_comb begin
    lt    = 1'b0;
    found = 1'b0;
    for (int unsigned i = 0; i < BCD_WORD_W / BCD_DIGIT_W; i++) begin
      if (!found &&
          (a[BCD_WORD_W-1-i*BCD_DIGIT_W -: BCD_DIGIT_W] != b[BCD_WORD_W-1-i*BCD_DIGIT_W -: BCD_DIGIT_W])) begin
        lt    = a[BCD_WORD_W-1-i*BCD_DIGIT_W -: BCD_DIGIT_W] < b[BCD_WORD_W-1-i*BCD_DIGIT_W -: BCD_DIGIT_W];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reaction_score_keeper.sv
// Captures completed reaction times, tracks best/attempts/false starts and
// drives the registered 4-digit display selection for the bcd7seg decoders.
module reaction_score_keeper
  import reaction_pkg::*;
#(
  parameter int unsigned CNT_MAX = 99
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  test_active,
  input  logic                  stop_test,
  input  logic                  request_test,
  input  logic [BCD_WORD_W-1:0] bcd_in,
  input  logic [1:0]            disp_sel,
  output logic [BCD_WORD_W-1:0] disp_out,
  output logic                  best_valid,
  output logic                  new_best,
  output logic                  false_start
);

  localparam logic [7:0] CNT_MAX_BCD = {4'(CNT_MAX / 10), 4'(CNT_MAX % 10)};

  logic                  ta_q;
  logic                  fs_q;
  logic [BCD_WORD_W-1:0] last;
  logic [BCD_WORD_W-1:0] best;
  logic [7:0]            attempts;
  logic [7:0]            faults;
  logic [BCD_WORD_W-1:0] disp_nxt;
  logic                  in_lt_best;
  logic                  done_evt;
  logic                  fs_cond;
  logic                  fs_evt;

  bcd_less4 u_less (
    .a  (bcd_in),
    .b  (best),
    .lt (in_lt_best)
  );

  assign done_evt = ta_q && !test_active;
  // fs_q remembers the qualified stop condition so a held button counts once.
  assign fs_cond  = stop_test && run && !test_active;
  assign fs_evt   = fs_cond && !fs_q;

  always_comb begin
    disp_nxt = '0;
    case (disp_sel_e'(disp_sel))
      DISP_LIVE:  disp_nxt = bcd_in;
      DISP_LAST:  disp_nxt = last;
      DISP_BEST:  disp_nxt = best_valid ? best : '0;
      DISP_STATS: disp_nxt = {attempts, faults};
      default:    disp_nxt = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ta_q        <= 1'b0;
      fs_q        <= 1'b0;
      last        <= '0;
      best        <= BEST_RESET;
      best_valid  <= 1'b0;
      attempts    <= '0;
      faults      <= '0;
      false_start <= 1'b0;
      new_best    <= 1'b0;
      disp_out    <= '0;
    end else begin
      ta_q     <= test_active;
      fs_q     <= fs_cond;
      new_best <= 1'b0;
      disp_out <= disp_nxt;
      if (done_evt) begin
        last     <= bcd_in;
        attempts <= bcd2_sat_inc(attempts, CNT_MAX_BCD);
        if (!best_valid || in_lt_best) begin
          best       <= bcd_in;
          best_valid <= 1'b1;
          new_best   <= 1'b1;
        end
      end
      if (fs_evt) begin
        faults      <= bcd2_sat_inc(faults, CNT_MAX_BCD);
        false_start <= 1'b1;
      end else if (request_test) begin
        false_start <= 1'b0;
      end
    end
  end

endmodule
